// File: rtl/ref_search_sched.sv
`default_nettype none
// ref_search_sched: raster full-search read sequencer from the reference memory to the PE array.
// Rev 1.0. Defining REF_SCHED_ABORT_EN adds an `abort` input that returns the block to IDLE.
module ref_search_sched #(
  parameter int BLK_ROWS = 32,
  parameter int SR_X     = 16,
  parameter int SR_Y     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pre_done,
  input  logic       pe_ready,
`ifdef REF_SCHED_ABORT_EN
  input  logic       abort,
`endif
  output logic [6:0] rd_address,
  output logic       rd8R_en,
  output logic [3:0] rdR_sel,
  output logic       pe_valid,
  output logic       pe_first,
  output logic       pe_last,
  output logic [3:0] search_x,
  output logic [6:0] search_y,
  output logic       busy,
  output logic       done
);

  localparam logic [6:0] ROW_LAST = 7'(BLK_ROWS - 1);
  localparam logic [3:0] X_LAST   = 4'(SR_X - 1);
  localparam logic [6:0] Y_LAST   = 7'(SR_Y - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PRE = 3'd1,
    S_ISSUE    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t     state, next_state;

  logic [6:0] r_row;
  logic [3:0] r_x;
  logic [6:0] r_y;

  // Tags of the read in flight; they reach the PE outputs one cycle later with the data.
  logic       r_pend;
  logic       r_pend_first;
  logic       r_pend_last;
  logic [3:0] r_pend_x;
  logic [6:0] r_pend_y;

  logic       w_issue;
  logic       w_clear;
  logic       w_abort;
  logic       w_at_end;

`ifdef REF_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_at_end = (r_row == ROW_LAST) && (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    w_issue    = 1'b0;
    w_clear    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_WAIT_PRE;
          w_clear    = 1'b1;
        end
      end
      S_WAIT_PRE: begin
        if (pre_done) begin
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pe_ready) begin
          w_issue = 1'b1;
          if (w_at_end) begin
            next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: next_state = S_IDLE == S_IDLE ? S_DONE : S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    // Abort wins over everything, including a simultaneous start.
    if (w_abort) begin
      next_state = S_IDLE;
      w_issue    = 1'b0;
      w_clear    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      rd_address   <= 7'd0;
      rd8R_en      <= 1'b1;
      rdR_sel      <= 4'd0;
      pe_valid     <= 1'b0;
      pe_first     <= 1'b0;
      pe_last      <= 1'b0;
      search_x     <= 4'd0;
      search_y     <= 7'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r_row        <= 7'd0;
      r_x          <= 4'd0;
      r_y          <= 7'd0;
      r_pend       <= 1'b0;
      r_pend_first <= 1'b0;
      r_pend_last  <= 1'b0;
      r_pend_x     <= 4'd0;
      r_pend_y     <= 7'd0;
    end else begin
      done     <= (state == S_DONE);
      // Busy stays up through the done pulse and drops together with it.
      busy     <= (next_state != S_IDLE) || (state == S_DONE);
      rd8R_en  <= ~w_issue;
      r_pend   <= w_issue;
      pe_valid <= r_pend;
      pe_first <= r_pend & r_pend_first;
      pe_last  <= r_pend & r_pend_last;
      if (r_pend) begin
        search_x <= r_pend_x;
        search_y <= r_pend_y;
      end

      if (w_clear) begin
        r_row <= 7'd0;
        r_x   <= 4'd0;
        r_y   <= 7'd0;
      end else if (w_issue) begin
        rd_address   <= r_y + r_row;
        rdR_sel      <= r_x;
        r_pend_first <= (r_row == 7'd0);
        r_pend_last  <= (r_row == ROW_LAST);
        r_pend_x     <= r_x;
        r_pend_y     <= r_y;
        if (r_row == ROW_LAST) begin
          r_row <= 7'd0;
          if (r_x == X_LAST) begin
            r_x <= 4'd0;
            r_y <= r_y + 7'd1;
          end else begin
            r_x <= r_x + 4'd1;
          end
        end else begin
          r_row <= r_row + 7'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ref_search_sched.sv
`default_nettype none
// tb_ref_search_sched: bench for ref_search_sched on a small 3-row, 3x2 search window.
module tb_ref_search_sched;

  localparam int BLK_ROWS = 3;
  localparam int SR_X     = 3;
  localparam int SR_Y     = 2;
  localparam int NREADS   = BLK_ROWS * SR_X * SR_Y;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       pre_done = 1'b0;
  logic       pe_ready = 1'b1;
  logic       abort    = 1'b0;
  logic [6:0] rd_address;
  logic       rd8R_en;
  logic [3:0] rdR_sel;
  logic       pe_valid;
  logic       pe_first;
  logic       pe_last;
  logic [3:0] search_x;
  logic [6:0] search_y;
  logic       busy;
  logic       done;

  ref_search_sched #(
    .BLK_ROWS(BLK_ROWS),
    .SR_X    (SR_X),
    .SR_Y    (SR_Y)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pre_done  (pre_done),
    .pe_ready  (pe_ready),
`ifdef REF_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .rd_address(rd_address),
    .rd8R_en   (rd8R_en),
    .rdR_sel   (rdR_sel),
    .pe_valid  (pe_valid),
    .pe_first  (pe_first),
    .pe_last   (pe_last),
    .search_x  (search_x),
    .search_y  (search_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int sel; longint when;} rd_t;
  typedef struct {int x; int y; int first; int last;} pe_t;

  rd_t    exp_rd[$];
  pe_t    exp_pe[$];
  longint exp_done[$];

  int     n_pass     = 0;
  int     n_total    = 0;
  int     n_done     = 0;
  int     n_done_exp = 0;
  longint cyc        = 0;
  logic   rst_q      = 1'b1;
  int     last_addr  = 0;
  int     last_sel   = 0;
  logic   prev_issue = 1'b0;
  logic   prev_done  = 1'b0;
  rd_t    mon_rd;
  pe_t    mon_pe;
  longint mon_done;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst | abort;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset rd_address", rd_address, 0);
      chk("reset rd8R_en", rd8R_en, 1);
      chk("reset rdR_sel", rdR_sel, 0);
      chk("reset pe_valid", pe_valid, 0);
      chk("reset pe_first", pe_first, 0);
      chk("reset pe_last", pe_last, 0);
      chk("reset search_x", search_x, 0);
      chk("reset search_y", search_y, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      prev_issue = 1'b0;
      prev_done  = 1'b0;
      last_addr  = 0;
      last_sel   = 0;
    end else begin
      chk("pe_valid one cycle after read", pe_valid, prev_issue);
      if (!rd8R_en) begin
        if (exp_rd.size() == 0) begin
          chk("read expected", 0, 1);
        end else begin
          mon_rd = exp_rd.pop_front();
          chk("rd_address", rd_address, mon_rd.addr);
          chk("rdR_sel", rdR_sel, mon_rd.sel);
          if (mon_rd.when >= 0) chk("read cycle", cyc, mon_rd.when);
          last_addr = mon_rd.addr;
          last_sel  = mon_rd.sel;
        end
      end else begin
        chk("rd_address hold", rd_address, last_addr);
        chk("rdR_sel hold", rdR_sel, last_sel);
      end
      if (pe_valid) begin
        if (exp_pe.size() == 0) begin
          chk("pe row expected", 0, 1);
        end else begin
          mon_pe = exp_pe.pop_front();
          chk("search_x", search_x, mon_pe.x);
          chk("search_y", search_y, mon_pe.y);
          chk("pe_first", pe_first, mon_pe.first);
          chk("pe_last", pe_last, mon_pe.last);
        end
      end
      if (done) begin
        n_done++;
        chk("busy during done", busy, 1);
        chk("rows outstanding at done", exp_rd.size() + exp_pe.size(), 0);
        if (exp_done.size() == 0) begin
          chk("done expected", 0, 1);
        end else begin
          mon_done = exp_done.pop_front();
          if (mon_done >= 0) chk("done cycle", cyc, mon_done);
        end
      end
      if (prev_done) begin
        chk("done single pulse", done, 0);
        chk("busy falls with done", busy, 0);
      end
      prev_issue = ~rd8R_en;
      prev_done  = done;
    end
  end

  // rmode: 0 pe_ready held high (exact timing known), 1 toggling, 2 random with pre_done noise.
  task automatic search(input int d, input int rmode, input bit mid, input int rst_at, input int abort_at);
    longint cp;
    int     k;
    int     d0;
    d0 = n_done;
    @(posedge clk); #1;
    start    = 1'b1;
    pe_ready = 1'b1;
    if (d == 0) begin
      pre_done = 1'b1;
      cp       = cyc + 1;
    end else begin
      pre_done = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        chk("busy while waiting for preload", busy, 1);
        chk("rd8R_en while waiting for preload", rd8R_en, 1);
        @(posedge clk); #1;
      end
      pre_done = 1'b1;
      cp       = cyc;
    end
    k = 0;
    for (int y = 0; y < SR_Y; y++)
      for (int x = 0; x < SR_X; x++)
        for (int r = 0; r < BLK_ROWS; r++) begin
          exp_rd.push_back('{y + r, x, (rmode == 0) ? (cp + 2 + k) : -1});
          exp_pe.push_back('{x, y, (r == 0) ? 1 : 0, (r == BLK_ROWS - 1) ? 1 : 0});
          k++;
        end
    exp_done.push_back((rmode == 0) ? (cp + NREADS + 3) : -1);
    n_done_exp++;

    for (int i = 0; i < 2000; i++) begin
      if (n_done != d0) break;
      @(posedge clk); #1;
      if (rst || abort) begin
        rst   = 1'b0;
        abort = 1'b0;
        exp_rd.delete();
        exp_pe.delete();
        exp_done.delete();
        n_done_exp--;
        pre_done = 1'b0;
        pe_ready = 1'b1;
        @(posedge clk); #1;
        return;
      end
      start = mid && (i == 8);
      if (rmode == 1) pe_ready = ~pe_ready;
      else if (rmode == 2) begin
        pe_ready = 1'($urandom_range(0, 1));
        if (i > 4) pre_done = 1'($urandom_range(0, 1));
      end
      if (rst_at > 0 && cyc == cp + 1 + rst_at) rst = 1'b1;
      if (abort_at > 0 && cyc == cp + 1 + abort_at) abort = 1'b1;
    end
    chk("done within cycle budget", (n_done != d0) ? 1 : 0, 1);
    @(posedge clk); #1;
    pre_done = 1'b0;
    pe_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    search(0, 0, 1'b0, 0, 0);
    search(0, 1, 1'b0, 0, 0);
    search(10, 0, 1'b0, 0, 0);
    search(0, 0, 1'b1, 0, 0);
    search(2, 0, 1'b0, 5, 0);
    search(0, 0, 1'b0, 0, 0);
    for (int t = 0; t < 3; t++) search(int'($urandom_range(0, 3)), 2, 1'b0, 0, 0);
`ifdef REF_SCHED_ABORT_EN
    search(1, 0, 1'b0, 0, 3);
    @(posedge clk); #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort beats start in idle", busy, 0);
    search(0, 0, 1'b0, 0, 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("leftover reads", exp_rd.size(), 0);
    chk("leftover pe rows", exp_pe.size(), 0);
    chk("leftover done", exp_done.size(), 0);
    chk("done pulse count", n_done, n_done_exp);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
